quad_gate_tester: RTL
=====================

# quad_gate_tester

- Synthesizable stimulus-and-check stage that wraps any quad 2-input gate IC model (SN74LS00/02/08/32/86 family) in the emulator.
- Drives the DUT's A1..A4/B1..B4 pins with an exhaustive, per-gate-rotated truth-table sequence.
- Samples Y1..Y4 after a settle interval, compares each output against a reference for the selected gate function, and reports per-gate pass/fail and an error count.
- Sits directly upstream (stimulus) and downstream (response) of the gate model; replaces hand-written initial-block benches on hardware targets.

## Interface
Parameters:
- SETTLE_CYCLES, default 2: clock cycles between driving a vector and sampling Y. Legal range 1..15; 0 is illegal.

Ports:
- CLK  input  1  single clock; all state changes on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  begin a run; sampled only in IDLE or DONE.
- FN  input  3  expected function: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR; 6/7 reserved. Latched on accepted START.
- A  output  4  A[0]..A[3] drive DUT A1..A4; registered.
- B  output  4  B[0]..B[3] drive DUT B1..B4; registered.
- Y  input  4  Y[0]..Y[3] from DUT Y1..Y4.
- BUSY  output  1  high in SETTLE/SAMPLE.
- DONE  output  1  high in DONE state.
- PASS  output  1  high in DONE when ERR_CNT == 0.
- ERR_CNT  output  5  total mismatches in the run, 0..16.
- FAIL_VEC  output  4  sticky per-gate mismatch flags.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Vector index k (2 bits, 0..3). Gate i (0..3) receives v = (k + i) mod 4, with A[i] = v[1] and B[i] = v[0].
  - Every gate sees all four input combinations.
  - Adjacent gates never see the same vector, so swapped pins are detected.
- IDLE:
  - A = B = 0.
  - On START with FN <= 5: latch FN; clear ERR_CNT and FAIL_VEC; set k = 0; drive vector 0; go to SETTLE.
  - START with FN 6/7 is ignored; the block stays in IDLE.
- SETTLE: counter loaded with SETTLE_CYCLES-1 on entry and decremented each cycle; at 0 go to SAMPLE.
- SAMPLE (one cycle):
  - mismatch[i] = Y[i] XOR expected(FN, A[i], B[i]).
  - ERR_CNT += popcount(mismatch); FAIL_VEC |= mismatch.
  - If k == 3 go to DONE; else k++, drive the new vectors, and go to SETTLE.
- DONE:
  - A = B = 0; results held.
  - START with FN <= 5 restarts exactly as from IDLE.
  - START with FN 6/7 is ignored; the block stays in DONE with results held.
- START while BUSY is ignored. FN changes during a run have no effect.
- ERR_CNT cannot overflow (at most 16 mismatches per run).

## Timing
- Reset: state IDLE; A = B = 0; BUSY = DONE = PASS = 0; ERR_CNT = 0; FAIL_VEC = 0.
- RST_N assertion mid-run aborts immediately and asynchronously to the reset values. No partial results are retained.
- Accepted START at edge t: at t+1, BUSY = 1 and A/B carry vector 0.
- Each vector occupies SETTLE_CYCLES + 1 cycles, with Y sampled in the last one.
- DONE rises 4·(SETTLE_CYCLES+1) cycles after the START edge; for SETTLE_CYCLES = 2 that is 12 cycles.
- BUSY falls in the same cycle DONE rises.
- Y is used combinationally from the DUT driven by registered A/B. SETTLE_CYCLES ≥ 1 guarantees at least one full cycle of settling.

## Structure
- Package quad_gate_tester_pkg holds:
  - state encoding constants;
  - FN codes;
  - the expected(fn, a, b) function.
- One sub-module, gate_ref_model: combinational 4-gate reference taking FN, A, and B and producing expected[3:0]. The checker and the benches reuse it.
- The top module holds the FSM, settle counter, vector index, and accumulators.

## Test plan
- Fault-free run: SN74LS08 DUT, FN=0, SETTLE_CYCLES=2, START pulse → DONE 12 cycles later; PASS=1, ERR_CNT=0, FAIL_VEC=4'b0000.
- Stuck output: Y[2] forced to 1 on an AND DUT → ERR_CNT=3, FAIL_VEC=4'b0100, PASS=0.
- Swapped pins: Y[0] and Y[1] swapped on an AND DUT → ERR_CNT=4, FAIL_VEC=4'b0011.
- Wrong function: AND DUT with FN=1 (NAND) → ERR_CNT=16, FAIL_VEC=4'hF.
- Reserved code and busy start:
  - START with FN=7 → remains IDLE, BUSY=0.
  - START re-pulsed while BUSY → completion time unchanged at 12 cycles.
- Reset mid-run: RST_N low during the second SETTLE → all outputs 0 immediately. A subsequent START completes a clean run with PASS=1.

Source files
------------

// File: rtl/quad_gate_tester_pkg.sv
// Shared types, function codes and reference helpers
// for the quad 2-input gate tester.
package quad_gate_tester_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [2:0] FN_AND  = 3'd0;
  localparam logic [2:0] FN_NAND = 3'd1;
  localparam logic [2:0] FN_OR   = 3'd2;
  localparam logic [2:0] FN_NOR  = 3'd3;
  localparam logic [2:0] FN_XOR  = 3'd4;
  localparam logic [2:0] FN_XNOR = 3'd5;

  function automatic logic expected(
    input logic [2:0] fn,
    input logic       a,
    input logic       b
  );
    logic r;
    case (fn)
      FN_AND:  r = a & b;
      FN_NAND: r = ~(a & b);
      FN_OR:   r = a | b;
      FN_NOR:  r = ~(a | b);
      FN_XOR:  r = a ^ b;
      FN_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Gate i gets v = k + i (mod 4); result packs {a[3:0], b[3:0]}.
  function automatic logic [7:0] vector(input logic [1:0] k);
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] v;
    for (int i = 0; i < 4; i++) begin
      v    = k + 2'(i);
      a[i] = v[1];
      b[i] = v[0];
    end
    return {a, b};
  endfunction

endpackage

// File: rtl/quad_gate_tester_if.sv
// Control, status and gate-pin bundle of the tester.
// master = tester side, slave = environment / gate model side.
interface quad_gate_tester_if;
  import quad_gate_tester_pkg::*;

  logic       START;
  logic [2:0] FN;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Y;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [4:0] ERR_CNT;
  logic [3:0] FAIL_VEC;

  modport master (
    input  START, FN, Y,
    output A, B, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC
  );

  modport slave (
    output START, FN, Y,
    input  A, B, BUSY, DONE, PASS, ERR_CNT, FAIL_VEC
  );

endinterface

// File: rtl/quad_gate_tester_gate_ref_model.sv
// Combinational reference for four 2-input gates
// of the selected function.
module gate_ref_model
  import quad_gate_tester_pkg::*;
(
  input  logic [2:0] fn,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] exp_y
);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      exp_y[i] = quad_gate_tester_pkg::expected(fn, a[i], b[i]);
    end
  end

endmodule

// File: rtl/quad_gate_tester.sv
// Stimulus/check stage for a quad 2-input gate model:
// rotated exhaustive vectors, settle, sample, accumulate.
module quad_gate_tester
  import quad_gate_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  quad_gate_tester_if.master bus
);

  // Legal SETTLE_CYCLES is 1..15, so the load fits 4 bits.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [1:0] k, k_n;
  logic [2:0] fn_q, fn_n;
  logic [3:0] a_q, a_n;
  logic [3:0] b_q, b_n;
  logic [4:0] err_q, err_n;
  logic [3:0] fv_q, fv_n;

  logic [3:0] exp_y;
  logic [3:0] mism;
  logic [4:0] mism_cnt;
  logic       start_ok;

  gate_ref_model u_ref (
    .fn    (fn_q),
    .a     (a_q),
    .b     (b_q),
    .exp_y (exp_y)
  );

  assign mism     = bus.Y ^ exp_y;
  assign mism_cnt = 5'(mism[0]) + 5'(mism[1])
                  + 5'(mism[2]) + 5'(mism[3]);
  assign start_ok = bus.START && (bus.FN <= FN_XNOR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
      k     <= '0;
      fn_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      err_q <= '0;
      fv_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      k     <= k_n;
      fn_q  <= fn_n;
      a_q   <= a_n;
      b_q   <= b_n;
      err_q <= err_n;
      fv_q  <= fv_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    k_n     = k;
    fn_n    = fn_q;
    a_n     = a_q;
    b_n     = b_q;
    err_n   = err_q;
    fv_n    = fv_q;
    unique case (state)
      S_IDLE, S_DONE: begin
        a_n = '0;
        b_n = '0;
        if (start_ok) begin
          state_n    = S_SETTLE;
          fn_n       = bus.FN;
          err_n      = '0;
          fv_n       = '0;
          k_n        = '0;
          cnt_n      = SETTLE_LOAD;
          {a_n, b_n} = vector(2'd0);
        end
      end
      S_SETTLE: begin
        if (cnt == '0) state_n = S_SAMPLE;
        else           cnt_n   = cnt - 4'd1;
      end
      S_SAMPLE: begin
        err_n = err_q + mism_cnt;
        fv_n  = fv_q | mism;
        if (k == 2'd3) begin
          state_n = S_DONE;
          a_n     = '0;
          b_n     = '0;
        end else begin
          state_n    = S_SETTLE;
          k_n        = k + 2'd1;
          cnt_n      = SETTLE_LOAD;
          {a_n, b_n} = vector(k + 2'd1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.BUSY     = (state == S_SETTLE) || (state == S_SAMPLE);
  assign bus.DONE     = (state == S_DONE);
  assign bus.PASS     = (state == S_DONE) && (err_q == '0);
  assign bus.ERR_CNT  = err_q;
  assign bus.FAIL_VEC = fv_q;

endmodule
